// File: rtl/combat_resolver_pkg.sv
// Shared fighter definitions: action one-hot bit positions, facing bit, health limits,
// resolver FSM states and small arithmetic helpers.
package combat_resolver_pkg;

    localparam int MV_WALKING   = 0;
    localparam int MV_JUMPING   = 1;
    localparam int MV_CROUCHING = 2;
    localparam int MV_PUNCHING  = 3;
    localparam int MV_SHIELDING = 4;
    localparam int MV_STANDING  = 5;
    localparam int FACING_BIT   = 6;

    localparam logic [3:0] MAX_HEALTH = 4'd15;

    typedef enum logic {
        ST_FIGHT = 1'b0,
        ST_KO    = 1'b1
    } state_t;

    function automatic logic [3:0] sat_sub(input logic [3:0] h, input logic [3:0] d);
        return (h < d) ? 4'd0 : h - d;
    endfunction

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/combat_resolver_hit_check.sv
// Combinational hit/block decision for one attacker against one defender.
module combat_resolver_hit_check
    import combat_resolver_pkg::*;
#(
    parameter logic [9:0] PUNCH_RANGE = 10'd48
) (
    input  logic       atk_facing_left,
    input  logic [9:0] atk_x,
    input  logic [5:0] def_move,
    input  logic [9:0] def_x,
    input  logic [3:0] def_shield,
    input  logic       def_invuln,
    output logic       hit,
    output logic       blocked
);

    logic in_range;
    logic facing;

    always_comb begin
        in_range = abs_diff(atk_x, def_x) <= PUNCH_RANGE;
        // Equal x satisfies both directions, so a stacked defender is always faced.
        facing   = atk_facing_left ? (def_x <= atk_x) : (def_x >= atk_x);
        hit      = in_range && facing && !def_move[MV_JUMPING] && !def_move[MV_CROUCHING]
                   && !def_invuln;
        blocked  = hit && def_move[MV_SHIELDING] && (def_shield != 4'd0);
    end

endmodule

// File: rtl/combat_resolver.sv
// Two-stage attack resolver: registers hit/block decisions, then applies damage, invulnerability
// windows and the FIGHT/KO round state.
module combat_resolver
    import combat_resolver_pkg::*;
#(
    parameter logic [9:0] PUNCH_RANGE   = 10'd48,
    parameter logic [3:0] DAMAGE        = 4'd2,
    parameter logic [3:0] BLOCK_DAMAGE  = 4'd0,
    parameter int         INVULN_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p0_attack_req,
    input  logic       p1_attack_req,
    input  logic [6:0] p0_action,
    input  logic [6:0] p1_action,
    input  logic [9:0] p0_x,
    input  logic [9:0] p1_x,
    input  logic [3:0] p0_shield,
    input  logic [3:0] p1_shield,
    input  logic       restart,
    output logic [3:0] p0_health,
    output logic [3:0] p1_health,
    output logic       p0_hit,
    output logic       p1_hit,
    output logic       p0_blocked,
    output logic       p1_blocked,
    output logic       game_over,
    output logic       winner
);

    localparam int              CNT_W    = $clog2(INVULN_CYCLES + 1);
    localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       h0_q, h0_d, h1_q, h1_d;
    logic [CNT_W-1:0] inv0_q, inv0_d, inv1_q, inv1_d;
    logic             hit_on0_p1_q, hit_on0_p1_d, blk_on0_p1_q, blk_on0_p1_d;
    logic             hit_on1_p1_q, hit_on1_p1_d, blk_on1_p1_q, blk_on1_p1_d;
    logic             p0_hit_q, p0_hit_d, p1_hit_q, p1_hit_d;
    logic             p0_blk_q, p0_blk_d, p1_blk_q, p1_blk_d;
    logic             winner_q, winner_d;
    logic             chk01_hit, chk01_blk, chk10_hit, chk10_blk;

    combat_resolver_hit_check #(.PUNCH_RANGE(PUNCH_RANGE)) u_chk01 (
        .atk_facing_left (p0_action[FACING_BIT]),
        .atk_x           (p0_x),
        .def_move        (p1_action[5:0]),
        .def_x           (p1_x),
        .def_shield      (p1_shield),
        .def_invuln      (inv1_q != '0),
        .hit             (chk01_hit),
        .blocked         (chk01_blk)
    );

    combat_resolver_hit_check #(.PUNCH_RANGE(PUNCH_RANGE)) u_chk10 (
        .atk_facing_left (p1_action[FACING_BIT]),
        .atk_x           (p1_x),
        .def_move        (p0_action[5:0]),
        .def_x           (p0_x),
        .def_shield      (p0_shield),
        .def_invuln      (inv0_q != '0),
        .hit             (chk10_hit),
        .blocked         (chk10_blk)
    );

    always_comb begin
        state_d      = state_q;
        h0_d         = h0_q;
        h1_d         = h1_q;
        winner_d     = winner_q;
        p0_hit_d     = 1'b0;
        p1_hit_d     = 1'b0;
        p0_blk_d     = 1'b0;
        p1_blk_d     = 1'b0;
        hit_on0_p1_d = 1'b0;
        blk_on0_p1_d = 1'b0;
        hit_on1_p1_d = 1'b0;
        blk_on1_p1_d = 1'b0;
        inv0_d       = (inv0_q != '0) ? inv0_q - CNT_W'(1) : '0;
        inv1_d       = (inv1_q != '0) ? inv1_q - CNT_W'(1) : '0;

        case (state_q)
            ST_FIGHT: begin
                // Stage 1: capture decisions; stage 2: apply what was captured last edge.
                hit_on1_p1_d = p0_attack_req && chk01_hit;
                blk_on1_p1_d = p0_attack_req && chk01_blk;
                hit_on0_p1_d = p1_attack_req && chk10_hit;
                blk_on0_p1_d = p1_attack_req && chk10_blk;

                if (hit_on0_p1_q) begin
                    h0_d     = sat_sub(h0_q, blk_on0_p1_q ? BLOCK_DAMAGE : DAMAGE);
                    p0_hit_d = !blk_on0_p1_q;
                    p0_blk_d = blk_on0_p1_q;
                    if (!blk_on0_p1_q) inv0_d = INV_LOAD;
                end
                if (hit_on1_p1_q) begin
                    h1_d     = sat_sub(h1_q, blk_on1_p1_q ? BLOCK_DAMAGE : DAMAGE);
                    p1_hit_d = !blk_on1_p1_q;
                    p1_blk_d = blk_on1_p1_q;
                    if (!blk_on1_p1_q) inv1_d = INV_LOAD;
                end

                // A double KO is awarded to player 0.
                if (h0_d == 4'd0 || h1_d == 4'd0) begin
                    state_d  = ST_KO;
                    winner_d = (h1_d == 4'd0) ? 1'b0 : 1'b1;
                end
            end
            ST_KO: begin
                if (restart) begin
                    state_d = ST_FIGHT;
                    h0_d    = MAX_HEALTH;
                    h1_d    = MAX_HEALTH;
                    inv0_d  = '0;
                    inv1_d  = '0;
                end
            end
            default: state_d = ST_FIGHT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FIGHT;
            h0_q         <= MAX_HEALTH;
            h1_q         <= MAX_HEALTH;
            inv0_q       <= '0;
            inv1_q       <= '0;
            hit_on0_p1_q <= 1'b0;
            blk_on0_p1_q <= 1'b0;
            hit_on1_p1_q <= 1'b0;
            blk_on1_p1_q <= 1'b0;
            p0_hit_q     <= 1'b0;
            p1_hit_q     <= 1'b0;
            p0_blk_q     <= 1'b0;
            p1_blk_q     <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            h0_q         <= h0_d;
            h1_q         <= h1_d;
            inv0_q       <= inv0_d;
            inv1_q       <= inv1_d;
            hit_on0_p1_q <= hit_on0_p1_d;
            blk_on0_p1_q <= blk_on0_p1_d;
            hit_on1_p1_q <= hit_on1_p1_d;
            blk_on1_p1_q <= blk_on1_p1_d;
            p0_hit_q     <= p0_hit_d;
            p1_hit_q     <= p1_hit_d;
            p0_blk_q     <= p0_blk_d;
            p1_blk_q     <= p1_blk_d;
            winner_q     <= winner_d;
        end
    end

    assign p0_health  = h0_q;
    assign p1_health  = h1_q;
    assign p0_hit     = p0_hit_q;
    assign p1_hit     = p1_hit_q;
    assign p0_blocked = p0_blk_q;
    assign p1_blocked = p1_blk_q;
    assign game_over  = (state_q == ST_KO);
    assign winner     = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Scoreboard bench for combat_resolver: expected round state is queued when a request is driven
// and compared when the resolver's stage-2 result appears.
module tb_combat_resolver;
    import combat_resolver_pkg::*;

    typedef struct {
        logic [3:0] h0;
        logic [3:0] h1;
        logic       hit0;
        logic       hit1;
        logic       blk0;
        logic       blk1;
        logic       go;
        logic       win;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, p0_attack_req, p1_attack_req, restart;
    logic [6:0] p0_action, p1_action;
    logic [9:0] p0_x, p1_x;
    logic [3:0] p0_shield, p1_shield;
    logic [3:0] p0_health, p1_health;
    logic       p0_hit, p1_hit, p0_blocked, p1_blocked, game_over, winner;

    exp_t       sb[$];
    logic [3:0] eh0, eh1;
    logic       ego, ewin;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    combat_resolver #(.INVULN_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .p0_attack_req (p0_attack_req),
        .p1_attack_req (p1_attack_req),
        .p0_action     (p0_action),
        .p1_action     (p1_action),
        .p0_x          (p0_x),
        .p1_x          (p1_x),
        .p0_shield     (p0_shield),
        .p1_shield     (p1_shield),
        .restart       (restart),
        .p0_health     (p0_health),
        .p1_health     (p1_health),
        .p0_hit        (p0_hit),
        .p1_hit        (p1_hit),
        .p0_blocked    (p0_blocked),
        .p1_blocked    (p1_blocked),
        .game_over     (game_over),
        .winner        (winner)
    );

    function automatic logic [6:0] act(input logic left, input int mv);
        logic [5:0] one;
        one = 6'd1 << mv;
        return {left, one};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " p0_health"}, 32'(p0_health), 32'(eh0));
        check({tag, " p1_health"}, 32'(p1_health), 32'(eh1));
        check({tag, " game_over"}, 32'(game_over), 32'(ego));
        check({tag, " winner"}, 32'(winner), 32'(ewin));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0; p0_attack_req = 1'b0; p1_attack_req = 1'b0; restart = 1'b0;
        eh0 = MAX_HEALTH; eh1 = MAX_HEALTH; ego = 1'b0; ewin = 1'b0;
        sb.delete();
        #2;
        check_state({tag, " reset"});
        check({tag, " reset pulses"}, 32'({p0_hit, p1_hit, p0_blocked, p1_blocked}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ho/bo: whether player 0/1 is expected to be hit / to block this request.
    task automatic fire(input string tag, input logic r0, input logic r1,
                        input logic ho0, input logic bo0, input logic ho1, input logic bo1);
        exp_t e;
        e = '{h0: 4'd0, h1: 4'd0, hit0: 1'b0, hit1: 1'b0, blk0: 1'b0, blk1: 1'b0, go: 1'b0, win: 1'b0};
        if (!ego) begin
            if (ho0) eh0 = (eh0 < (bo0 ? 4'd0 : 4'd2)) ? 4'd0 : eh0 - (bo0 ? 4'd0 : 4'd2);
            if (ho1) eh1 = (eh1 < (bo1 ? 4'd0 : 4'd2)) ? 4'd0 : eh1 - (bo1 ? 4'd0 : 4'd2);
            e.hit0 = ho0 && !bo0; e.blk0 = ho0 && bo0;
            e.hit1 = ho1 && !bo1; e.blk1 = ho1 && bo1;
            if (eh0 == 4'd0 || eh1 == 4'd0) begin
                ego  = 1'b1;
                ewin = (eh1 == 4'd0) ? 1'b0 : 1'b1;
            end
        end
        e.h0 = eh0; e.h1 = eh1; e.go = ego; e.win = ewin;
        sb.push_back(e);

        @(negedge clk);
        p0_attack_req = r0; p1_attack_req = r1;
        @(posedge clk);
        @(negedge clk);
        p0_attack_req = 1'b0; p1_attack_req = 1'b0;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " p0_health"}, 32'(p0_health), 32'(e.h0));
        check({tag, " p1_health"}, 32'(p1_health), 32'(e.h1));
        check({tag, " pulses"}, 32'({p0_hit, p1_hit, p0_blocked, p1_blocked}),
              32'({e.hit0, e.hit1, e.blk0, e.blk1}));
        check({tag, " game_over"}, 32'(game_over), 32'(e.go));
        check({tag, " winner"}, 32'(winner), 32'(e.win));
        @(posedge clk);
        #1;
        check({tag, " pulse width"}, 32'({p0_hit, p1_hit, p0_blocked, p1_blocked}), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic face_off();
        p0_x = 10'd100; p1_x = 10'd130;
        p0_action = act(1'b0, MV_PUNCHING);
        p1_action = act(1'b1, MV_STANDING);
        p0_shield = 4'd0; p1_shield = 4'd0;
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; p0_attack_req = 1'b0; p1_attack_req = 1'b0;
        face_off();

        // Basic hit, then a request lost to reset while sitting in stage 1.
        do_reset("t1");
        fire("t1 hit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset("t1b");
        @(negedge clk); p0_attack_req = 1'b1;
        @(posedge clk);
        @(negedge clk); p0_attack_req = 1'b0; reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        idle(2); #1;
        check_state("t1b discard");

        // Shield blocks; empty shield does not.
        do_reset("t2");
        p1_action = act(1'b1, MV_SHIELDING); p1_shield = 4'd5;
        fire("t2 block", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        p1_shield = 4'd0;
        fire("t2 noshield", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Misses, then the range boundary.
        do_reset("t3");
        p1_x = 10'd200;
        fire("t3 far", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p1_x = 10'd149;
        fire("t3 dx49", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p1_x = 10'd130; p0_action = act(1'b1, MV_PUNCHING);
        fire("t3 back", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p0_action = act(1'b0, MV_PUNCHING); p1_action = act(1'b1, MV_JUMPING);
        fire("t3 jump", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p1_action = act(1'b1, MV_CROUCHING);
        fire("t3 crouch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        p1_action = act(1'b1, MV_STANDING); p1_x = 10'd148;
        fire("t3 dx48", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset("t3b");
        p1_x = 10'd100; p0_action = act(1'b1, MV_PUNCHING);
        fire("t3 samex", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Invulnerability window.
        do_reset("t4");
        face_off();
        fire("t4 first", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        fire("t4 early", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        fire("t4 last", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        fire("t4 after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Trade.
        do_reset("t5");
        fire("t5 trade", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // KO by player 0, restart behaviour.
        do_reset("t6");
        for (int i = 0; i < 7; i++) begin
            fire("t6 wear", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            idle(7);
        end
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        #1;
        check_state("t6 restart in fight");
        fire("t6 ko", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        fire("t6 in ko", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        eh0 = MAX_HEALTH; eh1 = MAX_HEALTH; ego = 1'b0;
        check_state("t6 restart");

        // KO by player 1.
        for (int i = 0; i < 8; i++) begin
            fire("t6 p1wins", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            idle(7);
        end

        // Double KO goes to player 0.
        do_reset("t7");
        for (int i = 0; i < 8; i++) begin
            fire("t7 tie", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            idle(7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
